zeroheti_obi_xbar_rr: RTL and testbench

ZEROHETI_OBI_XBAR_RR -- requirements
Module: zeroheti_obi_xbar_rr

---
 rtl/zeroheti_pkg.sv | 24 ++
 rtl/zeroheti_rr_arb.sv | 57 +++++
 rtl/zeroheti_obi_xbar_rr.sv | 194 +++++++++++++++++++
 tb/tb_zeroheti_obi_xbar_rr.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroheti_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zeroheti_pkg -- crossbar address-rule type, default memory map, limits. Rev 1.0
// ---------------------------------------------------------------------------
package zeroheti_pkg;

    localparam int unsigned MaxMgr = 8;
    localparam int unsigned MaxSbr = 8;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
    } xbar_rule_t;

    // One 256 MiB window per subordinate; 0x4000_0000 and above is unmapped.
    localparam xbar_rule_t [3:0] DefaultXbarRules = {
        {32'h3000_0000, 32'hF000_0000},
        {32'h2000_0000, 32'hF000_0000},
        {32'h1000_0000, 32'hF000_0000},
        {32'h0000_0000, 32'hF000_0000}
    };

endpackage
`default_nettype wire

// File: rtl/zeroheti_rr_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zeroheti_rr_arb -- round-robin arbiter; pointer moves past the winner on handshake. Rev 1.0
// ---------------------------------------------------------------------------
module zeroheti_rr_arb #(
    parameter int unsigned N = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          hs_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!valid_o && req_i[cand[IW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IW-1:0];
            end
        end
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (valid_o && hs_i) begin
            ptr_d = (idx_o == IW'(N-1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/zeroheti_obi_xbar_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zeroheti_obi_xbar_rr -- OBI crossbar, per-subordinate round-robin, in-order ID FIFOs. Rev 1.0
// ---------------------------------------------------------------------------
module zeroheti_obi_xbar_rr
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumMgr   = 3,
    parameter int unsigned NumSbr   = 4,
    parameter int unsigned MaxTrans = 2,
    parameter xbar_rule_t [NumSbr-1:0] AddrRules = zeroheti_pkg::DefaultXbarRules,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumMgr-1:0]            mgr_req_i,
    input  logic [NumMgr-1:0]            mgr_we_i,
    input  logic [NumMgr-1:0][AW-1:0]    mgr_addr_i,
    input  logic [NumMgr-1:0][DW-1:0]    mgr_wdata_i,
    input  logic [NumMgr-1:0][DW/8-1:0]  mgr_be_i,
    output logic [NumMgr-1:0]            mgr_gnt_o,
    output logic [NumMgr-1:0]            mgr_rvalid_o,
    output logic [NumMgr-1:0]            mgr_err_o,
    output logic [NumMgr-1:0][DW-1:0]    mgr_rdata_o,
    output logic [NumSbr-1:0]            sbr_req_o,
    output logic [NumSbr-1:0]            sbr_we_o,
    output logic [NumSbr-1:0][AW-1:0]    sbr_addr_o,
    output logic [NumSbr-1:0][DW-1:0]    sbr_wdata_o,
    output logic [NumSbr-1:0][DW/8-1:0]  sbr_be_o,
    input  logic [NumSbr-1:0]            sbr_gnt_i,
    input  logic [NumSbr-1:0]            sbr_rvalid_i,
    input  logic [NumSbr-1:0]            sbr_err_i,
    input  logic [NumSbr-1:0][DW-1:0]    sbr_rdata_i
);

    // Target index NumSbr is the internal error subordinate.
    localparam int unsigned NumTgt = NumSbr + 1;
    localparam int unsigned MW     = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned TW     = $clog2(NumTgt);
    localparam int unsigned CW     = $clog2(MaxTrans + 1);
    localparam int unsigned PW     = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

    logic [NumMgr-1:0][TW-1:0]              tgt;
    logic [NumMgr-1:0]                      elig;
    logic [NumMgr-1:0][CW-1:0]              cnt_q, cnt_d;
    logic [NumMgr-1:0][TW-1:0]              cur_q, cur_d;
    logic [NumTgt-1:0][NumMgr-1:0]          arb_req, arb_gnt;
    logic [NumTgt-1:0][MW-1:0]              arb_idx;
    logic [NumTgt-1:0]                      arb_vld, tgt_gnt, hs, rsp_vld, pop;
    logic [NumTgt-1:0][DW-1:0]              rdata_ext;
    logic [NumTgt-1:0]                      err_ext;
    logic [NumTgt-1:0][MaxTrans-1:0][MW-1:0] fifo_q;
    logic [NumTgt-1:0][PW-1:0]              wptr_q, rptr_q;
    logic [NumTgt-1:0][CW-1:0]              fcnt_q;
    logic [MW-1:0]                          head;
    logic                                   err_rvalid_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tgt_gnt   = {1'b1, sbr_gnt_i};
    assign rsp_vld   = {err_rvalid_q, sbr_rvalid_i};
    assign rdata_ext = {{DW{1'b0}}, sbr_rdata_i};
    assign err_ext   = {1'b1, sbr_err_i};
    assign hs        = arb_vld & tgt_gnt;

    // Decode and eligibility: a manager may only stream to one target at a time.
    always_comb begin
        tgt     = '0;
        elig    = '0;
        arb_req = '0;
        for (int m = 0; m < NumMgr; m++) begin
            tgt[m] = TW'(NumSbr);
            for (int s = int'(NumSbr) - 1; s >= 0; s--) begin
                if ((mgr_addr_i[m] & AddrRules[s].mask) == AddrRules[s].base) begin
                    tgt[m] = TW'(s);
                end
            end
            elig[m] = mgr_req_i[m] && (cnt_q[m] != CW'(MaxTrans)) &&
                      ((cnt_q[m] == '0) || (cur_q[m] == tgt[m]));
            for (int t = 0; t < NumTgt; t++) begin
                arb_req[t][m] = elig[m] && (tgt[m] == TW'(t)) && (fcnt_q[t] != CW'(MaxTrans));
            end
        end
    end

    for (genvar t = 0; t < NumTgt; t++) begin : g_arb
        zeroheti_rr_arb #(.N(NumMgr)) u_arb (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .req_i   (arb_req[t]),
            .hs_i    (tgt_gnt[t]),
            .gnt_o   (arb_gnt[t]),
            .idx_o   (arb_idx[t]),
            .valid_o (arb_vld[t])
        );
    end

    always_comb begin
        sbr_req_o   = '0;
        sbr_we_o    = '0;
        sbr_addr_o  = '0;
        sbr_wdata_o = '0;
        sbr_be_o    = '0;
        for (int s = 0; s < NumSbr; s++) begin
            sbr_req_o[s] = arb_vld[s];
            if (arb_vld[s]) begin
                sbr_we_o[s]    = mgr_we_i[arb_idx[s]];
                sbr_addr_o[s]  = mgr_addr_i[arb_idx[s]];
                sbr_wdata_o[s] = mgr_wdata_i[arb_idx[s]];
                sbr_be_o[s]    = mgr_be_i[arb_idx[s]];
            end
        end
        mgr_gnt_o = '0;
        for (int t = 0; t < NumTgt; t++) begin
            for (int m = 0; m < NumMgr; m++) begin
                mgr_gnt_o[m] = mgr_gnt_o[m] | (arb_gnt[t][m] & tgt_gnt[t]);
            end
        end
    end

    // Responses with no recorded transaction are silently dropped.
    always_comb begin
        mgr_rvalid_o = '0;
        mgr_rdata_o  = '0;
        mgr_err_o    = '0;
        pop          = '0;
        head         = '0;
        for (int t = 0; t < NumTgt; t++) begin
            if (rsp_vld[t] && (fcnt_q[t] != '0)) begin
                pop[t]             = 1'b1;
                head               = fifo_q[t][rptr_q[t]];
                mgr_rvalid_o[head] = 1'b1;
                mgr_rdata_o[head]  = rdata_ext[t];
                mgr_err_o[head]    = err_ext[t];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        cur_d = cur_q;
        for (int m = 0; m < NumMgr; m++) begin
            if (mgr_gnt_o[m] && !mgr_rvalid_o[m]) begin
                cnt_d[m] = cnt_q[m] + 1'b1;
            end else if (!mgr_gnt_o[m] && mgr_rvalid_o[m]) begin
                cnt_d[m] = cnt_q[m] - 1'b1;
            end
            if (mgr_gnt_o[m]) begin
                cur_d[m] = tgt[m];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            cur_q        <= '0;
            fifo_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            fcnt_q       <= '0;
            err_rvalid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            err_rvalid_q <= hs[NumSbr];
            for (int t = 0; t < NumTgt; t++) begin
                if (hs[t]) begin
                    fifo_q[t][wptr_q[t]] <= arb_idx[t];
                    wptr_q[t]            <= ptr_inc(wptr_q[t]);
                end
                if (pop[t]) begin
                    rptr_q[t] <= ptr_inc(rptr_q[t]);
                end
                if (hs[t] && !pop[t]) begin
                    fcnt_q[t] <= fcnt_q[t] + 1'b1;
                end else if (!hs[t] && pop[t]) begin
                    fcnt_q[t] <= fcnt_q[t] - 1'b1;
                end
            end
        end
    end

    for (genvar s = 0; s < NumSbr; s++) begin : g_rsp_chk
        a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(sbr_rvalid_i[s] && (fcnt_q[s] == '0)))
            else $error("xbar: rvalid on subordinate %0d with no outstanding id", s);
    end

endmodule
`default_nettype wire

// File: tb/tb_zeroheti_obi_xbar_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_zeroheti_obi_xbar_rr -- directed stimulus with a response scoreboard per manager. Rev 1.0
// ---------------------------------------------------------------------------
module tb_zeroheti_obi_xbar_rr;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [2:0]       mgr_req_i, mgr_we_i;
    logic [2:0][31:0] mgr_addr_i, mgr_wdata_i;
    logic [2:0][3:0]  mgr_be_i;
    logic [2:0]       mgr_gnt_o, mgr_rvalid_o, mgr_err_o;
    logic [2:0][31:0] mgr_rdata_o;
    logic [3:0]       sbr_req_o, sbr_we_o;
    logic [3:0][31:0] sbr_addr_o, sbr_wdata_o;
    logic [3:0][3:0]  sbr_be_o;
    logic [3:0]       sbr_gnt_i, sbr_rvalid_i, sbr_err_i;
    logic [3:0][31:0] sbr_rdata_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[3][$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    zeroheti_obi_xbar_rr #(.NumMgr(3), .NumSbr(4), .MaxTrans(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .mgr_req_i    (mgr_req_i),
        .mgr_we_i     (mgr_we_i),
        .mgr_addr_i   (mgr_addr_i),
        .mgr_wdata_i  (mgr_wdata_i),
        .mgr_be_i     (mgr_be_i),
        .mgr_gnt_o    (mgr_gnt_o),
        .mgr_rvalid_o (mgr_rvalid_o),
        .mgr_err_o    (mgr_err_o),
        .mgr_rdata_o  (mgr_rdata_o),
        .sbr_req_o    (sbr_req_o),
        .sbr_we_o     (sbr_we_o),
        .sbr_addr_o   (sbr_addr_o),
        .sbr_wdata_o  (sbr_wdata_o),
        .sbr_be_o     (sbr_be_o),
        .sbr_gnt_i    (sbr_gnt_i),
        .sbr_rvalid_i (sbr_rvalid_i),
        .sbr_err_i    (sbr_err_i),
        .sbr_rdata_i  (sbr_rdata_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clr();
        mgr_req_i    = '0;
        mgr_we_i     = '0;
        mgr_addr_i   = '0;
        mgr_wdata_i  = '0;
        mgr_be_i     = '0;
        sbr_gnt_i    = '0;
        sbr_rvalid_i = '0;
        sbr_err_i    = '0;
        sbr_rdata_i  = '0;
    endtask

    function automatic logic [31:0] rdata_or();
        return mgr_rdata_o[0] | mgr_rdata_o[1] | mgr_rdata_o[2];
    endfunction

    // Monitor: every routed response must match the oldest expectation of that manager.
    always @(negedge clk) begin
        if (rst_ni === 1'b1) begin
            for (int m = 0; m < 3; m++) begin
                if (mgr_rvalid_o[m]) begin
                    if (exp_q[m].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp mgr%0d: rdata %0h with nothing outstanding", m, mgr_rdata_o[m]);
                    end else begin
                        exp_t e;
                        e = exp_q[m].pop_front();
                        chk($sformatf("rsp_rdata_m%0d", m), 64'(mgr_rdata_o[m]), 64'(e.rdata));
                        chk($sformatf("rsp_err_m%0d", m), 64'(mgr_err_o[m]), 64'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   n0, n1, exp_m;
        logic hs_prev;
        logic [5:0] t4_gnt;
        logic [5:0] t4_rv;
        logic [31:0] t4_data[3];

        clr();
        rst_ni = 1'b0;
        repeat (3) mid();
        chk("reset_sbr_req", 64'(sbr_req_o), 64'h0);
        chk("reset_mgr_gnt", 64'(mgr_gnt_o), 64'h0);
        chk("reset_mgr_rvalid", 64'(mgr_rvalid_o), 64'h0);
        chk("reset_rdata", 64'(rdata_or()), 64'h0);
        step();
        rst_ni = 1'b1;

        // Round-robin fairness: mgr0/mgr1 hammer sbr2, responses one cycle after grant.
        n0 = 0; n1 = 0; exp_m = 0; hs_prev = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step();
            mgr_req_i       = 3'b011;
            mgr_addr_i[0]   = 32'h2000_0000;
            mgr_addr_i[1]   = 32'h2000_0004;
            sbr_gnt_i       = 4'b0100;
            sbr_rvalid_i[2] = hs_prev;
            sbr_rdata_i[2]  = 32'hA000_0000 + 32'(c);
            mid();
            chk("rr_gnt", 64'(mgr_gnt_o), 64'(3'(1 << exp_m)));
            if (mgr_gnt_o[0]) n0++;
            if (mgr_gnt_o[1]) n1++;
            exp_q[exp_m].push_back('{32'hA000_0000 + 32'(c + 1), 1'b0});
            hs_prev = sbr_req_o[2] & sbr_gnt_i[2];
            exp_m   = 1 - exp_m;
        end
        step();
        mgr_req_i       = '0;
        sbr_rvalid_i[2] = hs_prev;
        sbr_rdata_i[2]  = 32'hA000_0000 + 32'd100;
        mid();
        step();
        clr();
        chk("rr_share_m0", 64'(n0), 64'd50);
        chk("rr_share_m1", 64'(n1), 64'd50);

        // Read to sbr1 (response 3 cycles later) alongside a delayed-grant write to sbr3.
        step();
        mgr_req_i      = 3'b011;
        mgr_addr_i[0]  = 32'h1000_0000;
        mgr_we_i[1]    = 1'b1;
        mgr_addr_i[1]  = 32'h3000_0010;
        mgr_wdata_i[1] = 32'h1234_5678;
        mgr_be_i[1]    = 4'b0101;
        sbr_gnt_i      = 4'b0010;
        mid();
        chk("rd_sbr_req", 64'(sbr_req_o), 64'b1010);
        chk("rd_sbr_addr", 64'(sbr_addr_o[1]), 64'h1000_0000);
        chk("wr_sbr_we", 64'(sbr_we_o), 64'b1000);
        chk("wr_sbr_wdata", 64'(sbr_wdata_o[3]), 64'h1234_5678);
        chk("wr_sbr_be", 64'(sbr_be_o[3]), 64'b0101);
        chk("rd_gnt", 64'(mgr_gnt_o), 64'b001);
        exp_q[0].push_back('{32'hDEAD_BEEF, 1'b0});
        step();
        mgr_req_i[0] = 1'b0;
        sbr_gnt_i    = 4'b1000;
        mid();
        chk("wr_gnt", 64'(mgr_gnt_o), 64'b010);
        chk("idle_rvalid", 64'(mgr_rvalid_o), 64'h0);
        chk("idle_rdata_zero", 64'(rdata_or()), 64'h0);
        exp_q[1].push_back('{32'h0, 1'b0});
        step();
        clr();
        sbr_rvalid_i[3] = 1'b1;
        mid();
        chk("wr_rsp_route", 64'(mgr_rvalid_o), 64'b010);
        step();
        clr();
        sbr_rvalid_i[1] = 1'b1;
        sbr_rdata_i[1]  = 32'hDEAD_BEEF;
        mid();
        chk("rd_rsp_route", 64'(mgr_rvalid_o), 64'b001);
        step();
        clr();
        mid();
        chk("post_rsp_idle_err", 64'(mgr_err_o), 64'h0);
        chk("post_rsp_idle_rdata", 64'(rdata_or()), 64'h0);

        // Unmapped write goes to the error subordinate.
        step();
        mgr_req_i[2]   = 1'b1;
        mgr_we_i[2]    = 1'b1;
        mgr_addr_i[2]  = 32'hF000_0000;
        mgr_wdata_i[2] = 32'h0000_CAFE;
        mgr_be_i[2]    = 4'hF;
        mid();
        chk("err_gnt", 64'(mgr_gnt_o), 64'b100);
        chk("err_no_sbr_req", 64'(sbr_req_o), 64'h0);
        exp_q[2].push_back('{32'h0, 1'b1});
        step();
        clr();
        mid();
        chk("err_rsp_route", 64'(mgr_rvalid_o), 64'b100);
        chk("err_rsp_no_sbr_req", 64'(sbr_req_o), 64'h0);
        step();
        mid();
        chk("err_rsp_single", 64'(mgr_rvalid_o), 64'h0);

        // Outstanding limit: third read held off until the first response retires.
        t4_gnt     = 6'b100011;
        t4_rv      = 6'b010000;
        t4_data[0] = 32'h11; t4_data[1] = 32'h22; t4_data[2] = 32'h33;
        n0 = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            mgr_req_i[0]    = 1'b1;
            mgr_addr_i[0]   = 32'h0000_0100;
            sbr_gnt_i       = 4'b0001;
            sbr_rvalid_i[0] = t4_rv[c];
            sbr_rdata_i[0]  = 32'h11;
            mid();
            chk($sformatf("maxtrans_gnt_c%0d", c), 64'(mgr_gnt_o[0]), 64'(t4_gnt[c]));
            if (t4_gnt[c]) begin
                exp_q[0].push_back('{t4_data[n0], 1'b0});
                n0++;
            end
        end
        for (int c = 1; c < 3; c++) begin
            step();
            clr();
            sbr_rvalid_i[0] = 1'b1;
            sbr_rdata_i[0]  = t4_data[c];
            mid();
            chk("maxtrans_rsp", 64'(mgr_rvalid_o), 64'b001);
        end
        step();
        clr();

        // Target switch blocked while a different target still owes a response.
        step();
        mgr_req_i[0]  = 1'b1;
        mgr_addr_i[0] = 32'h0000_0200;
        sbr_gnt_i     = 4'b0011;
        mid();
        chk("switch_first_gnt", 64'(mgr_gnt_o), 64'b001);
        exp_q[0].push_back('{32'hA5, 1'b0});
        for (int c = 0; c < 3; c++) begin
            step();
            mgr_addr_i[0]   = 32'h1000_0000;
            sbr_rvalid_i[0] = (c == 2);
            sbr_rdata_i[0]  = 32'hA5;
            mid();
            chk("switch_masked_gnt", 64'(mgr_gnt_o), 64'h0);
            chk("switch_masked_req", 64'(sbr_req_o), 64'h0);
        end
        step();
        sbr_rvalid_i[0] = 1'b0;
        mid();
        chk("switch_gnt_after_rsp", 64'(mgr_gnt_o), 64'b001);
        chk("switch_req_after_rsp", 64'(sbr_req_o), 64'b0010);
        exp_q[0].push_back('{32'h5A, 1'b0});
        step();
        clr();
        step();
        sbr_rvalid_i[1] = 1'b1;
        sbr_rdata_i[1]  = 32'h5A;
        mid();
        step();
        clr();

        // Reset with two transactions in flight; responses during reset are dropped.
        step();
        mgr_req_i     = 3'b011;
        mgr_addr_i[0] = 32'h0000_0300;
        mgr_addr_i[1] = 32'h1000_0400;
        sbr_gnt_i     = 4'b0011;
        mid();
        chk("inflight_gnt", 64'(mgr_gnt_o), 64'b011);
        for (int c = 0; c < 2; c++) begin
            step();
            clr();
            rst_ni       = 1'b0;
            sbr_rvalid_i = 4'b0011;
            sbr_rdata_i[0] = 32'hBAD0;
            sbr_rdata_i[1] = 32'hBAD1;
            mid();
            chk("rst_rvalid", 64'(mgr_rvalid_o), 64'h0);
            chk("rst_rdata", 64'(rdata_or()), 64'h0);
            chk("rst_sbr_req", 64'(sbr_req_o), 64'h0);
        end
        step();
        clr();
        rst_ni = 1'b1;
        mid();
        chk("post_rst_rvalid", 64'(mgr_rvalid_o), 64'h0);
        chk("post_rst_gnt", 64'(mgr_gnt_o), 64'h0);
        step();
        mgr_req_i[0]  = 1'b1;
        mgr_addr_i[0] = 32'h1000_0000;
        sbr_gnt_i     = 4'b0011;
        mid();
        chk("post_rst_m0_gnt", 64'(mgr_gnt_o), 64'b001);
        exp_q[0].push_back('{32'h77, 1'b0});
        step();
        mgr_req_i     = 3'b010;
        mgr_addr_i[1] = 32'h0000_0000;
        mid();
        chk("post_rst_m1_gnt", 64'(mgr_gnt_o), 64'b010);
        exp_q[1].push_back('{32'h88, 1'b0});
        step();
        clr();
        sbr_rvalid_i[1] = 1'b1;
        sbr_rdata_i[1]  = 32'h77;
        mid();
        chk("post_rst_rsp_m0", 64'(mgr_rvalid_o), 64'b001);
        step();
        clr();
        sbr_rvalid_i[0] = 1'b1;
        sbr_rdata_i[0]  = 32'h88;
        mid();
        chk("post_rst_rsp_m1", 64'(mgr_rvalid_o), 64'b010);
        step();
        clr();
        repeat (2) mid();

        chk("scoreboard_drained", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
